ascent_sequencer: RTL and testbench

ASCENT_SEQUENCER -- requirements
Module: ascent_sequencer

---
 rtl/ascent_pkg.sv | 22 ++
 rtl/ascent_sequencer_if.sv | 36 +++
 rtl/cycle_counter.sv | 26 ++
 rtl/ascent_sequencer.sv | 128 ++++++++++++
 tb/tb_ascent_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ascent_pkg.sv
// Shared definitions for the ascent sequencer: phase encodings, the altitude
// fixed-point scale, and a counter-width helper.
package ascent_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BURN       = 3'd1,
    ST_WAIT_VALID = 3'd2,
    ST_GUIDE      = 3'd3,
    ST_CUTOFF     = 3'd4,
    ST_DONE       = 3'd5,
    ST_FAULT      = 3'd6
  } phase_e;

  // Altitudes carry nine fractional decimal digits.
  localparam logic [63:0] ALT_SCALE = 64'd1_000_000_000;

  function automatic int count_width(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/ascent_sequencer_if.sv
// Command, altitude feedback and control-output bundle between the flight
// controller and the ascent sequencer.
interface ascent_sequencer_if #(
  parameter int N = 64
);
  // Command semantics: launch is a one-cycle strobe taken only while the
  // sequencer is idle (no back-pressure, a strobe outside IDLE is dropped);
  // abort is a level sampled every clock; noair_altitude == 0 marks the
  // ballistic altitude as not yet valid.
  logic         launch;
  logic         abort;
  logic [N-1:0] noair_altitude;
  logic [N-1:0] current_altitude;

  logic         altitude_enable;
  logic         distance_enable;
  logic         integ_clear;
  logic         trig_sel;
  logic [2:0]   phase;
  logic         cutoff;
  logic         done;
  logic         fault;

  modport master (
    output launch, abort, noair_altitude, current_altitude,
    input  altitude_enable, distance_enable, integ_clear, trig_sel,
           phase, cutoff, done, fault
  );

  modport slave (
    input  launch, abort, noair_altitude, current_altitude,
    output altitude_enable, distance_enable, integ_clear, trig_sel,
           phase, cutoff, done, fault
  );

endinterface

// File: rtl/cycle_counter.sv
// Loadable down-counter that stops at zero; zero flag is a decode of the count.
module cycle_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ascent_sequencer.sv
// Ascent phase sequencer: burn timer, wait for valid ballistic altitude,
// guided climb to target altitude with timeout, settle, then done or fault.
module ascent_sequencer
  import ascent_pkg::*;
#(
  parameter int           N             = 64,
  parameter logic [N-1:0] TARGET_ALT    = N'(64'd188000 * ALT_SCALE),
  parameter int           BURN_CYCLES   = 100,
  parameter int           GUIDE_TIMEOUT = 100000,
  parameter int           SETTLE_CYCLES = 4
) (
  input logic              clk,
  input logic              resetb,
  ascent_sequencer_if.slave bus
);

  localparam int TMR_MAX = (BURN_CYCLES > SETTLE_CYCLES) ? BURN_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = count_width(TMR_MAX);
  localparam logic [TMR_W-1:0] BURN_LOAD   = TMR_W'((BURN_CYCLES > 0) ? BURN_CYCLES - 1 : 0);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  localparam int GW = count_width(GUIDE_TIMEOUT);
  localparam logic [GW-1:0] GUIDE_MAX  = GW'(GUIDE_TIMEOUT);
  localparam logic [GW-1:0] GUIDE_LAST = GW'((GUIDE_TIMEOUT > 0) ? GUIDE_TIMEOUT - 1 : 0);

  phase_e            state;
  phase_e            next_state;
  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_value;
  logic              tmr_en;
  logic [TMR_W-1:0]  tmr_count;
  logic              tmr_zero;
  logic [GW-1:0]     guide_cnt;
  logic              alt_reached;
  logic              guide_expire;
  logic              noair_valid;

  assign alt_reached  = (bus.current_altitude >= TARGET_ALT);
  assign guide_expire = (guide_cnt >= GUIDE_LAST);
  assign noair_valid  = (bus.noair_altitude != '0);
  assign tmr_en       = (state == ST_BURN) || (state == ST_CUTOFF);

  // One timer serves both BURN and CUTOFF; the two phases never overlap.
  cycle_counter #(.W(TMR_W)) u_timer (
    .clk   (clk),
    .rst   (resetb),
    .load  (tmr_load),
    .value (tmr_value),
    .en    (tmr_en),
    .count (tmr_count),
    .zero  (tmr_zero)
  );

  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    case (state)
      ST_IDLE: begin
        if (bus.launch) begin
          next_state = ST_BURN;
          tmr_load   = 1'b1;
          tmr_value  = BURN_LOAD;
        end
      end
      ST_BURN: begin
        if (bus.abort)     next_state = ST_FAULT;
        else if (tmr_zero) next_state = ST_WAIT_VALID;
      end
      ST_WAIT_VALID: begin
        if (bus.abort)        next_state = ST_FAULT;
        else if (noair_valid) next_state = ST_GUIDE;
      end
      ST_GUIDE: begin
        // Reaching altitude beats the timeout; both beat a valid-drop.
        if (bus.abort) begin
          next_state = ST_FAULT;
        end else if (alt_reached) begin
          next_state = ST_CUTOFF;
          tmr_load   = 1'b1;
          tmr_value  = SETTLE_LOAD;
        end else if (guide_expire) begin
          next_state = ST_FAULT;
        end else if (!noair_valid) begin
          next_state = ST_WAIT_VALID;
        end
      end
      ST_CUTOFF: begin
        if (bus.abort)     next_state = ST_FAULT;
        else if (tmr_zero) next_state = ST_DONE;
      end
      ST_DONE:  next_state = ST_DONE;
      ST_FAULT: next_state = ST_FAULT;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetb) begin
      state               <= ST_IDLE;
      guide_cnt           <= '0;
      bus.altitude_enable <= 1'b0;
      bus.distance_enable <= 1'b0;
      bus.integ_clear     <= 1'b0;
      bus.trig_sel        <= 1'b0;
      bus.cutoff          <= 1'b0;
      bus.done            <= 1'b0;
      bus.fault           <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == ST_IDLE) && (next_state == ST_BURN)) begin
        guide_cnt <= '0;
      end else if ((state == ST_GUIDE) && (guide_cnt != GUIDE_MAX)) begin
        guide_cnt <= guide_cnt + 1'b1;
      end
      bus.altitude_enable <= (next_state == ST_GUIDE);
      bus.distance_enable <= (next_state == ST_GUIDE);
      bus.integ_clear     <= (state == ST_IDLE) && (next_state == ST_BURN);
      bus.trig_sel        <= (next_state == ST_GUIDE) && (state == ST_GUIDE) && !bus.trig_sel;
      bus.cutoff          <= (state == ST_GUIDE) && (next_state == ST_CUTOFF);
      bus.done            <= (next_state == ST_DONE);
      bus.fault           <= (next_state == ST_FAULT);
    end
  end

  assign bus.phase = state;

endmodule

// File: tb/tb_ascent_sequencer.sv
// Directed bench for ascent_sequencer: per-cycle vector table plus hand-written
// latency sequences for guidance entry, altitude ramp and settle.
module tb_ascent_sequencer;

  localparam logic [63:0] T  = 64'd188_000_000_000_000;
  localparam logic [63:0] LO = 64'd187_999_999_999_999;
  localparam logic [63:0] Q  = 64'd47_000_000_000_000;

  typedef struct {
    logic        rst;
    logic        launch;
    logic        abort;
    logic [63:0] noair;
    logic [63:0] cur;
    int          reps;
    logic [2:0]  ph;
    logic        en;
    logic        ts;
    logic        alt;
    logic        ic;
    logic        co;
    logic        dn;
    logic        ft;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetb;
  always #5 clk = ~clk;

  ascent_sequencer_if #(.N(64)) bus ();

  ascent_sequencer #(
    .N             (64),
    .TARGET_ALT    (T),
    .BURN_CYCLES   (10),
    .GUIDE_TIMEOUT (20),
    .SETTLE_CYCLES (4)
  ) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  // ---------------- scoreboard state ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [9:0] exp_q[$];
  vec_t       vecs[$];

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic l, input logic a,
                       input logic [63:0] na, input logic [63:0] ca);
    resetb               = r;
    bus.launch           = l;
    bus.abort            = a;
    bus.noair_altitude   = na;
    bus.current_altitude = ca;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int rst, input int launch, input int abort,
                     input logic [63:0] noair, input logic [63:0] cur, input int reps,
                     input int ph, input int en, input int ts, input int alt,
                     input int ic, input int co, input int dn, input int ft);
    vec_t v;
    v.rst = 1'(rst); v.launch = 1'(launch); v.abort = 1'(abort);
    v.noair = noair; v.cur = cur; v.reps = reps;
    v.ph = 3'(ph); v.en = 1'(en); v.ts = 1'(ts); v.alt = 1'(alt);
    v.ic = 1'(ic); v.co = 1'(co); v.dn = 1'(dn); v.ft = 1'(ft);
    vecs.push_back(v);
  endtask

  function automatic logic [9:0] observed();
    return {bus.phase, bus.altitude_enable, bus.distance_enable, bus.trig_sel,
            bus.integ_clear, bus.cutoff, bus.done, bus.fault};
  endfunction

  task automatic check_vec(input int idx, input int rep, input logic [9:0] got);
    logic [9:0] exp;
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL vec%0d.%0d {phase,aen,den,trig,clr,cut,done,fault} got=%b exp=%b",
               idx, rep, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus + checking ----------------
  initial begin
    int         n;
    logic [63:0] cur_v;
    drive(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);

    // rst launch abort noair cur reps | phase en ts alt clr cut done fault
    // nominal flight to DONE
    add(1,0,0,64'd0,64'd0,   2,  0,0,0,0, 0,0,0,0);
    add(0,0,0,64'd0,64'd0,   3,  0,0,0,0, 0,0,0,0);
    add(0,1,0,64'd5,64'd0,   1,  1,0,0,0, 1,0,0,0);
    add(0,1,0,64'd5,64'd0,   1,  1,0,0,0, 0,0,0,0);
    add(0,0,0,64'd5,64'd0,   8,  1,0,0,0, 0,0,0,0);
    add(0,0,0,64'd5,64'd0,   1,  2,0,0,0, 0,0,0,0);
    add(0,0,0,64'd5,64'd0,   1,  3,1,0,0, 0,0,0,0);
    add(0,0,0,64'd5,64'd1000,1,  3,1,1,0, 0,0,0,0);
    add(0,0,0,64'd5,LO,      2,  3,1,0,1, 0,0,0,0);
    add(0,0,0,64'd5,T,       1,  4,0,0,0, 0,1,0,0);
    add(0,0,0,64'd5,T,       3,  4,0,0,0, 0,0,0,0);
    add(0,0,0,64'd5,T,       1,  5,0,0,0, 0,0,1,0);
    add(0,1,0,64'd5,T,       2,  5,0,0,0, 0,0,1,0);
    add(0,0,1,64'd5,T,       1,  5,0,0,0, 0,0,1,0);
    // launch+abort in IDLE, valid drop in GUIDE, then guide timeout
    add(1,0,0,64'd0,64'd0,   1,  0,0,0,0, 0,0,0,0);
    add(0,1,1,64'd0,64'd0,   1,  1,0,0,0, 1,0,0,0);
    add(0,0,0,64'd0,64'd0,   9,  1,0,0,0, 0,0,0,0);
    add(0,0,0,64'd0,64'd0,   3,  2,0,0,0, 0,0,0,0);
    add(0,0,0,64'd7,LO,      1,  3,1,0,0, 0,0,0,0);
    add(0,0,0,64'd7,LO,      4,  3,1,1,1, 0,0,0,0);
    add(0,0,0,64'd0,LO,      3,  2,0,0,0, 0,0,0,0);
    add(0,0,0,64'd7,LO,      1,  3,1,0,0, 0,0,0,0);
    add(0,0,0,64'd7,LO,     14,  3,1,1,1, 0,0,0,0);
    add(0,0,0,64'd7,LO,      1,  6,0,0,0, 0,0,0,1);
    add(0,1,1,64'd7,LO,      2,  6,0,0,0, 0,0,0,1);
    // timeout and target in the same cycle -> CUTOFF, then abort in CUTOFF
    add(1,0,0,64'd0,64'd0,   1,  0,0,0,0, 0,0,0,0);
    add(0,1,0,64'd9,64'd0,   1,  1,0,0,0, 1,0,0,0);
    add(0,0,0,64'd9,64'd0,   9,  1,0,0,0, 0,0,0,0);
    add(0,0,0,64'd9,LO,      1,  2,0,0,0, 0,0,0,0);
    add(0,0,0,64'd9,LO,      1,  3,1,0,0, 0,0,0,0);
    add(0,0,0,64'd9,LO,     19,  3,1,1,1, 0,0,0,0);
    add(0,0,0,64'd9,T,       1,  4,0,0,0, 0,1,0,0);
    add(0,0,1,64'd9,T,       1,  6,0,0,0, 0,0,0,1);
    // abort in BURN, reset in GUIDE, abort in WAIT_VALID
    add(1,0,0,64'd0,64'd0,   1,  0,0,0,0, 0,0,0,0);
    add(0,1,0,64'd0,64'd0,   1,  1,0,0,0, 1,0,0,0);
    add(0,0,1,64'd0,64'd0,   1,  6,0,0,0, 0,0,0,1);
    add(0,0,0,64'd0,64'd0,   2,  6,0,0,0, 0,0,0,1);
    add(1,0,0,64'd0,64'd0,   1,  0,0,0,0, 0,0,0,0);
    add(0,1,0,64'd3,64'd0,   1,  1,0,0,0, 1,0,0,0);
    add(0,0,0,64'd3,64'd0,   9,  1,0,0,0, 0,0,0,0);
    add(0,0,0,64'd3,64'd0,   1,  2,0,0,0, 0,0,0,0);
    add(0,0,0,64'd3,64'd0,   1,  3,1,0,0, 0,0,0,0);
    add(0,0,0,64'd3,64'd0,   2,  3,1,1,1, 0,0,0,0);
    add(1,0,0,64'd3,64'd0,   1,  0,0,0,0, 0,0,0,0);
    add(0,0,0,64'd3,64'd0,   2,  0,0,0,0, 0,0,0,0);
    add(0,1,0,64'd0,64'd0,   1,  1,0,0,0, 1,0,0,0);
    add(0,0,0,64'd0,64'd0,   9,  1,0,0,0, 0,0,0,0);
    add(0,0,0,64'd0,64'd0,   1,  2,0,0,0, 0,0,0,0);
    add(0,0,1,64'd0,64'd0,   1,  6,0,0,0, 0,0,0,1);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        drive(vecs[i].rst, vecs[i].launch, vecs[i].abort, vecs[i].noair, vecs[i].cur);
        exp_q.push_back({vecs[i].ph, vecs[i].en, vecs[i].en,
                         vecs[i].ts ^ (vecs[i].alt & r[0]),
                         vecs[i].ic, vecs[i].co, vecs[i].dn, vecs[i].ft});
        tick();
        check_vec(i, r, observed());
      end
    end

    // launch-to-GUIDE latency: 10 BURN clocks plus one WAIT_VALID clock
    drive(1'b1, 1'b0, 1'b0, 64'd5, 64'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 64'd5, 64'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 64'd5, 64'd0);
    n = 0;
    while (bus.phase !== 3'd3 && n < 50) begin
      tick();
      n++;
    end
    check_int("guide_latency", n, 11);

    // altitude ramp in quarter steps reaches the target on the fourth sample
    cur_v = 64'd0;
    n = 0;
    while (bus.cutoff !== 1'b1 && n < 20) begin
      cur_v = cur_v + Q;
      drive(1'b0, 1'b0, 1'b0, 64'd5, cur_v);
      tick();
      n++;
    end
    check_int("ramp_to_cutoff", n, 4);
    check_int("cutoff_aen", int'(bus.altitude_enable), 0);
    check_int("cutoff_den", int'(bus.distance_enable), 0);
    tick();
    check_int("cutoff_width", int'(bus.cutoff), 0);
    n = 1;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check_int("settle_to_done", n, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
